// File: rtl/sram_ctrl_pkg.sv
// Shared widths, idle pin levels and request bundle for the
// gf180mcu 512x8 SRAM port controller.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_WIDTH = 9;
  localparam int SRAM_DATA_WIDTH = 8;

  localparam logic SRAM_CEN_IDLE     = 1'b1;
  localparam logic SRAM_GWEN_IDLE    = 1'b1;
  localparam logic SRAM_WEN_BIT_IDLE = 1'b1;
  localparam logic [SRAM_DATA_WIDTH-1:0]
    SRAM_WEN_IDLE = '1;

  typedef struct packed {
    logic                       write;
    logic [SRAM_ADDR_WIDTH-1:0] addr;
    logic [SRAM_DATA_WIDTH-1:0] wdata;
    logic [SRAM_DATA_WIDTH-1:0] wmask;
  } sram_req_t;

endpackage

// File: rtl/sram_port_ctrl_if.sv
// Request/response channels between core logic and the
// SRAM port controller.
interface sram_port_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] req_wmask;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    output req_wmask,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    input  req_wmask,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_rdata
  );

endinterface

// File: rtl/sram_resp_fifo.sv
// Synchronous in-order FIFO holding SRAM read data
// until the consumer takes it.
module sram_resp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int WIDTH = SRAM_DATA_WIDTH,
  parameter int DEPTH = 3,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_rdata = r_mem[r_rptr];

  // A full FIFO still accepts a push if it pops on the same edge.
  assign w_push = i_push & (~o_full | i_pop);
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= nxt(r_wptr);
      if (w_pop)  r_rptr <= nxt(r_rptr);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_port_ctrl.sv
// Valid/ready front end driving one gf180mcu 512x8 SRAM
// macro, with credit-limited in-order read responses.
module sram_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int RESP_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_port_ctrl_if.slave       bus,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int UW = CW + 1;

  logic          r_rd_pending;
  logic          w_fire;
  logic          w_wr_fire;
  logic          w_rd_fire;
  logic          w_pop;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic [UW-1:0] w_used;

  assign w_fire    = bus.req_valid & bus.req_ready;
  assign w_wr_fire = w_fire & bus.req_write;
  assign w_rd_fire = w_fire & ~bus.req_write;

  assign sram_a    = bus.req_addr;
  assign sram_d    = bus.req_wdata;
  assign sram_cen  = w_fire ? 1'b0 : SRAM_CEN_IDLE;
  assign sram_gwen = w_wr_fire ? 1'b0 : SRAM_GWEN_IDLE;
  assign sram_wen  = w_wr_fire ? ~bus.req_wmask
                   : {DATA_WIDTH{SRAM_WEN_BIT_IDLE}};

  // Credits cover the read in flight plus queued data.
  assign w_used = {1'b0, w_count} + UW'(r_rd_pending);
  assign bus.req_ready =
    rst_n & (w_used < UW'(RESP_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_pending <= 1'b0;
    else        r_rd_pending <= w_rd_fire;
  end

  assign bus.resp_valid = ~w_empty;
  assign w_pop = ~w_empty & bus.resp_ready;

  sram_resp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RESP_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_rd_pending),
    .i_wdata (sram_q),
    .i_pop   (w_pop),
    .o_rdata (bus.resp_rdata),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(r_rd_pending && w_full && !w_pop));
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl with a behavioural
// model of the SRAM macro.
module tb_sram_port_ctrl;
  import sram_ctrl_pkg::*;

  localparam int AW = SRAM_ADDR_WIDTH;
  localparam int DW = SRAM_DATA_WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_port_ctrl_if #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) bus ();

  logic          cen;
  logic          gwen;
  logic [DW-1:0] wen;
  logic [AW-1:0] a;
  logic [DW-1:0] d;
  logic [DW-1:0] q;

  sram_port_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESP_DEPTH (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .sram_cen  (cen),
    .sram_gwen (gwen),
    .sram_wen  (wen),
    .sram_a    (a),
    .sram_d    (d),
    .sram_q    (q)
  );

  logic [DW-1:0] mem [2**AW];

  always @(posedge clk) begin
    if (!cen) begin
      if (!gwen) mem[a] <= (mem[a] & wen) | (d & ~wen);
      else       q <= mem[a];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(
    input logic          v,
    input logic          w,
    input logic [AW-1:0] ad,
    input logic [DW-1:0] wd,
    input logic [DW-1:0] m
  );
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = ad;
    bus.req_wdata = wd;
    bus.req_wmask = m;
    #1;
  endtask

  task automatic idle();
    set_req(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic wr(
    input logic [AW-1:0] ad,
    input logic [DW-1:0] wd
  );
    set_req(1'b1, 1'b1, ad, wd, 8'hFF);
    check("wr_ready", bus.req_ready, 1);
    tick();
    idle();
  endtask

  task automatic rd(
    input logic [AW-1:0] ad,
    input logic [DW-1:0] exp
  );
    set_req(1'b1, 1'b0, ad, '0, '0);
    check("rd_cen", cen, 0);
    check("rd_gwen", gwen, 1);
    check("rd_wen", wen, 8'hFF);
    tick();
    idle();
    check("rd_lat1_valid", bus.resp_valid, 0);
    tick();
    check("rd_lat2_valid", bus.resp_valid, 1);
    check("rd_data", bus.resp_rdata, exp);
    tick();
    check("rd_popped", bus.resp_valid, 0);
  endtask

  initial begin
    bus.resp_ready = 1'b1;
    set_req(1'b1, 1'b1, '0, '0, 8'hFF);
    #1;
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_cen", cen, 1);
    check("rst_gwen", gwen, 1);
    check("rst_wen", wen, SRAM_WEN_IDLE);
    tick();
    tick();
    rst_n = 1'b1;
    idle();

    for (int i = 0; i < 10; i++) begin
      check("idle_cen", cen, 1);
      check("idle_gwen", gwen, 1);
      check("idle_wen", wen, 8'hFF);
      check("idle_ready", bus.req_ready, 1);
      tick();
    end

    set_req(1'b1, 1'b1, 9'h005, 8'hA5, 8'hFF);
    check("w1_cen", cen, 0);
    check("w1_gwen", gwen, 0);
    check("w1_wen", wen, 8'h00);
    check("w1_a", a, 9'h005);
    check("w1_d", d, 8'hA5);
    tick();
    idle();
    rd(9'h005, 8'hA5);

    set_req(1'b1, 1'b1, 9'h005, 8'h00, 8'h0F);
    check("mw_wen", wen, 8'hF0);
    tick();
    rd(9'h005, 8'hA0);

    set_req(1'b1, 1'b1, 9'h005, 8'hFF, 8'h00);
    check("zm_cen", cen, 0);
    check("zm_wen", wen, 8'hFF);
    tick();
    idle();
    tick();
    tick();
    check("zm_no_resp", bus.resp_valid, 0);
    rd(9'h005, 8'hA0);

    wr(9'h010, 8'h11);
    wr(9'h011, 8'h22);
    wr(9'h012, 8'h33);
    wr(9'h013, 8'h44);
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 1'b0, 9'(16 + i), '0, '0);
      check("bp_ready_acc", bus.req_ready, 1);
      tick();
    end
    set_req(1'b1, 1'b0, 9'h013, '0, '0);
    check("bp_ready_full", bus.req_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_stall_ready", bus.req_ready, 0);
      check("bp_hold_valid", bus.resp_valid, 1);
      check("bp_hold_data", bus.resp_rdata, 8'h11);
    end
    bus.resp_ready = 1'b1;
    #1;
    tick();
    check("bp_r2", bus.resp_rdata, 8'h22);
    check("bp_ready_again", bus.req_ready, 1);
    tick();
    idle();
    check("bp_r3", bus.resp_rdata, 8'h33);
    tick();
    check("bp_r4_valid", bus.resp_valid, 1);
    check("bp_r4", bus.resp_rdata, 8'h44);
    tick();
    check("bp_drained", bus.resp_valid, 0);

    for (int i = 0; i < 16; i++) begin
      wr(9'(32 + i), 8'hC0 ^ 8'(i));
    end
    for (int i = 0; i < 16; i++) begin
      set_req(1'b1, 1'b0, 9'(32 + i), '0, '0);
      check("tp_ready", bus.req_ready, 1);
      tick();
      if (i > 0) begin
        check("tp_valid", bus.resp_valid, 1);
        check("tp_data", bus.resp_rdata,
              8'hC0 ^ 8'(i - 1));
      end
    end
    idle();
    tick();
    check("tp_last_valid", bus.resp_valid, 1);
    check("tp_last", bus.resp_rdata, 8'hCF);
    tick();
    check("tp_drained", bus.resp_valid, 0);

    set_req(1'b1, 1'b0, 9'h005, '0, '0);
    tick();
    set_req(1'b1, 1'b1, 9'h005, 8'hFF, 8'hFF);
    rst_n = 1'b0;
    #1;
    check("mr_resp_valid", bus.resp_valid, 0);
    check("mr_req_ready", bus.req_ready, 0);
    check("mr_cen", cen, 1);
    check("mr_gwen", gwen, 1);
    check("mr_wen", wen, 8'hFF);
    tick();
    tick();
    idle();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("mr_no_resp", bus.resp_valid, 0);
      check("mr_ready", bus.req_ready, 1);
      tick();
    end
    rd(9'h005, 8'hA0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_port_ctrl.md
# sram_port_ctrl

Request/response front end for one `gf180mcu_fd_ip_sram__sram512x8m8wm1` macro inside `chip_core`. It accepts read and write requests from core logic on a valid/ready channel and drives the macro's active-low control pins with correct per-cycle timing. It captures macro read data and returns it in order on a valid/ready response channel with back-pressure. Idle cycles keep the macro deselected (`CEN`=1).

## Interface
Parameters:
- `ADDR_WIDTH`, default 9: macro address width (512 words).
- `DATA_WIDTH`, default 8: macro word width; also the width of the write mask.
- `RESP_DEPTH`, default 3: response FIFO entries. Must be ≥2; a value of ≥3 is needed for one read per cycle.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock; also drives the macro `CLK`.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted on the current edge if `req_valid` is also high.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  word address.
- `req_wdata`  in  DATA_WIDTH  write data.
- `req_wmask`  in  DATA_WIDTH  per-bit write enable, active high.
- `resp_valid`  out  1  read data available.
- `resp_ready`  in  1  consumer takes the response.
- `resp_rdata`  out  DATA_WIDTH  read data.
- `sram_cen`  out  1  macro `CEN`, active low.
- `sram_gwen`  out  1  macro `GWEN`, active low.
- `sram_wen`  out  DATA_WIDTH  macro `WEN`, active low per bit.
- `sram_a`  out  ADDR_WIDTH  macro `A`.
- `sram_d`  out  DATA_WIDTH  macro `D`.
- `sram_q`  in  DATA_WIDTH  macro `Q`.

## Operation
- `fire` = `req_valid & req_ready`.
- Macro pins are combinational from the request:
  - `sram_a` = `req_addr`, `sram_d` = `req_wdata`.
  - `sram_cen` = `~fire`.
  - `sram_gwen` = `~(fire & req_write)`.
  - `sram_wen` = `~({DATA_WIDTH{fire & req_write}} & req_wmask)`.
- Writes generate no response. Reads generate exactly one response each.
- In-flight tracking:
  - A 1-bit `rd_pending` register is set by a read fire and cleared on the following edge.
  - On the edge after a read fire, `sram_q` is pushed into the response FIFO.
- `req_ready` = `rst_n & (rd_pending + fifo_count < RESP_DEPTH)`.
  - `req_ready` never depends on `req_valid`, `req_write` or `resp_ready`; there is no combinational path from the response channel.
  - The credit check applies to writes too. This is a deliberate simplification: writes may stall while the FIFO is full.
- Response FIFO: synchronous, in-order, RESP_DEPTH entries.
  - `resp_valid` = FIFO non-empty; `resp_rdata` = head entry.
  - Pop when `resp_valid & resp_ready`.
  - A push and a pop on the same edge leave the count unchanged.
  - Push to a full FIFO cannot occur, because of the credit rule; a simulation assertion checks this.
- Read-after-write to the same address on consecutive accepted cycles returns the new data; ordering is provided by the macro.
- `req_wmask` = 0 on a write gives a `CEN` cycle with no bits written. This is legal, and no response is produced.
- Reset (asserted asynchronously at any time, including mid-read):
  - FIFO is emptied and `rd_pending` is cleared.
  - `resp_valid`=0 and `req_ready`=0.
  - `sram_cen`=1, `sram_gwen`=1, `sram_wen`=all-1s.
  - A read lost to reset produces no response after reset is released.
- Reset deassertion is synchronised externally. The first request can be accepted on the first edge after `rst_n` goes high.

## Timing
- Read request fires on edge N, which is also the macro sample edge.
- `sram_q` is valid after edge N and is captured on edge N+1.
- `resp_valid` is high after edge N+1. Read latency is 2 edges.
- Sustained throughput: one read per cycle with `resp_ready`=1 and `RESP_DEPTH`≥3. `RESP_DEPTH`=2 inserts one bubble per two reads.
- Writes complete on the fire edge.
- `resp_valid` and `resp_rdata` hold stable while `resp_ready`=0.

## Structure
- Package `sram_ctrl_pkg` holds:
  - `SRAM_ADDR_WIDTH`=9 and `SRAM_DATA_WIDTH`=8.
  - Idle pin constants: `CEN`, `GWEN` and `WEN` all 1.
  - `sram_req_t` struct: write, addr, wdata, wmask.
- Sub-module `sram_resp_fifo`: a parameterised synchronous FIFO with async active-low reset, exposing count, full and empty.
- Top level holds the pin logic, `rd_pending`, the credit compare and the assertions.
- The macro instance stays in `chip_core`. Only pins cross the boundary.

## Test plan
- **Write then read:** write addr 0x05 data 0xA5 mask 0xFF, then read 0x05.
  - Write cycle pins: `CEN`=0, `GWEN`=0, `WEN`=0x00.
  - `resp_rdata`=0xA5 two edges after the read fires.
- **Masked write:** write 0x05 data 0x00 mask 0x0F after the write above, then read.
  - `WEN`=0xF0 on the write cycle.
  - Read returns 0xA0.
- **Back-pressure:** hold `resp_ready`=0 and issue 4 reads to addresses holding 0x11, 0x22, 0x33, 0x44.
  - 3 reads are accepted, then `req_ready`=0.
  - Releasing `resp_ready` returns 0x11, 0x22, 0x33 in order, then accepts the 4th read, which returns 0x44.
- **Throughput:** 16 back-to-back reads with `resp_ready`=1.
  - `req_ready` stays 1 throughout.
  - 16 responses appear on consecutive cycles starting 2 edges after the first fire.
- **Reset mid-operation:** assert `rst_n` low in the cycle after a read fires.
  - Outputs immediately show `resp_valid`=0, `req_ready`=0, `sram_cen`=1, `sram_wen`=0xFF.
  - No response appears after release.
- **Idle:** `req_valid`=0 for 10 cycles. `sram_cen`, `sram_gwen` and `sram_wen` hold all-1s.
